rx_pkt_arbiter: RTL and testbench
=================================

# rx_pkt_arbiter

Packet-granular round-robin arbiter that shares the single 512-bit RX filter pipeline between up to four AXI-Stream sources, for example the CMAC adapter and a loopback or test-generator path. It sits directly upstream of the filter pipeline in the 250 MHz box. It grants one source at a time and holds the grant until that source's `tlast` beat. It tags each output beat with the source index and keeps a per-source packet counter for the register block.

## Interface
Parameters:
- `NUM_PORTS`, default 2: number of requesting sources, legal range 2..4.
- `TUSER_W`, default 48: width of tuser per port.

Ports:
- `aclk`  input  1  Single clock domain for the whole block.
- `aresetn`  input  1  Reset: asynchronous assert, active-low.
- `s_axis_tvalid`  input  NUM_PORTS  Per-source valid.
- `s_axis_tdata`  input  NUM_PORTS*512  Per-source data; port i occupies bits [i*512 +: 512].
- `s_axis_tkeep`  input  NUM_PORTS*64  Per-source byte enables.
- `s_axis_tlast`  input  NUM_PORTS  Per-source end of packet.
- `s_axis_tuser`  input  NUM_PORTS*TUSER_W  Per-source sideband.
- `s_axis_tready`  output  NUM_PORTS  Per-source ready.
- `m_axis_tvalid`  output  1  Valid toward the filter pipeline.
- `m_axis_tdata`  output  512  Data toward the filter pipeline.
- `m_axis_tkeep`  output  64  Byte enables toward the filter pipeline.
- `m_axis_tlast`  output  1  End of packet toward the filter pipeline.
- `m_axis_tuser`  output  TUSER_W  Sideband, passed through unmodified.
- `m_axis_tid`  output  2  Index of the source of the current beat.
- `m_axis_tready`  input  1  Downstream ready.
- `pkt_count`  output  NUM_PORTS*32  Per-source count of packets forwarded (tlast beats accepted).

## Operation
State machine with two states, ARB and XFER. Registers: `grant` (2b), `last_grant` (2b), output register stage, counters.

ARB:
- Compute the first source with `s_axis_tvalid` high, scanning `last_grant+1, last_grant+2, …` modulo NUM_PORTS.
- If one is found: latch `grant` and go to XFER.
- If none is found: stay in ARB.
- All `s_axis_tready` are 0 in ARB.

XFER:
- `s_axis_tready[grant] = out_ready`, where `out_ready = !m_axis_tvalid || m_axis_tready`.
- All other `s_axis_tready` are 0.
- On an accepted beat (`s_axis_tvalid[grant] && s_axis_tready[grant]`):
  - Load the output register with data, keep, last and user from source `grant`.
  - Set `m_axis_tid = grant` and `m_axis_tvalid = 1`.
- If an accepted beat has `tlast = 1`:
  - `last_grant <= grant`.
  - `pkt_count[grant]` increments.
  - Go to ARB.
- If `out_ready` is high and no beat is accepted, clear `m_axis_tvalid`.
- The grant is never revoked mid-packet, even if the granted source deasserts `tvalid` (bubble) while others request.

General rules:
- Output beats are never reordered or interleaved; every packet appears contiguously on m_axis.
- `pkt_count` is 32-bit and wraps from 0xFFFFFFFF to 0 with no saturation.
- At most one counter changes per cycle.
- A single-beat packet (`tlast` on the first beat) is legal and counts as one packet.
- `tkeep` and `tuser` contents are not inspected.

## Timing
Reset values:
- State ARB, `grant = 0`, `last_grant = NUM_PORTS-1` (so port 0 has first priority).
- `m_axis_tvalid = 0`; `m_axis_tdata`, `tkeep`, `tlast`, `tuser` and `tid` are 0.
- `s_axis_tready` all 0; `pkt_count` all 0.

Reset mid-packet:
- Outputs clear immediately on `aresetn` falling edge, with no flush and no partial-packet completion.
- The source is responsible for discarding the packet.

Latency:
- Request seen in ARB at cycle N → `grant` latched at edge N+1.
- First beat accepted in cycle N+1 → visible on m_axis at cycle N+2.
- Each subsequent beat follows 1 cycle after acceptance.

Throughput:
- One beat per cycle within a packet.
- Exactly one idle cycle (ARB) between consecutive packets, including back-to-back packets from the same source.

Backpressure:
- While `m_axis_tvalid && !m_axis_tready`, the output register holds stable and `s_axis_tready` is 0.
- Once m_axis is valid, `m_axis_*` and `m_axis_tid` stay stable until the transfer completes.

Simultaneous events:
- All sources requesting in ARB → the round-robin pointer decides.
- `tlast` accepted in the same cycle that another source raises `tvalid` → the new request is evaluated in the following ARB cycle.

## Test plan
1. Reset, then port 0 sends a 3-beat packet with port 1 idle → m_axis shows 3 beats with `tid = 0` starting 2 cycles after `tvalid`; `pkt_count[0] = 1`, `pkt_count[1] = 0`.
2. Ports 0 and 1 both continuously present 2-beat packets, `m_axis_tready = 1` → output packet sequence tid 0,1,0,1 with one idle cycle between packets; after 8 packets each counter equals 4.
3. Port 1 mid-packet deasserts `tvalid` for 3 cycles while port 0 requests → no port-0 beat appears until port 1's `tlast`; port 1's beats stay contiguous and in order.
4. `m_axis_tready` toggled 1,0,0,1 during a 4-beat packet → no beat lost or duplicated; `m_axis_tdata` is stable while stalled; `s_axis_tready` is 0 during stalls.
5. Preload `pkt_count[0]` to 0xFFFFFFFE by forcing, then send 2 single-beat packets on port 0 → count reads 0xFFFFFFFF, then 0x00000000.
6. Assert `aresetn = 0` asynchronously between clock edges mid-packet → `m_axis_tvalid` drops immediately; after release, a new packet on port 1 is granted with port 0 holding first priority.

Source files
------------

// File: rtl/rx_pkt_arbiter.sv
// rtl/rx_pkt_arbiter.sv - packet-granular round-robin arbiter in front of the RX filter pipeline
//
// Purpose: shares one 512-bit AXI-Stream output between NUM_PORTS sources. A grant is
// held from the first beat to the tlast beat of a packet, so packets never interleave.
// Each output beat carries the index of its source on m_axis_tid, and a per-source
// 32-bit wrapping counter tracks forwarded packets.
//
// Ports:
//   aclk, aresetn        clock, asynchronous active-low reset
//   s_axis_*             NUM_PORTS packed source streams (port i at [i*W +: W])
//   m_axis_*             registered output stream toward the filter pipeline
//   m_axis_tid           source index of the beat currently on m_axis
//   pkt_count            per-source packet counters, port i at [i*32 +: 32]
module rx_pkt_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int TUSER_W   = 48
) (
  input  logic                         aclk,
  input  logic                         aresetn,
  input  logic [NUM_PORTS-1:0]         s_axis_tvalid,
  input  logic [NUM_PORTS*512-1:0]     s_axis_tdata,
  input  logic [NUM_PORTS*64-1:0]      s_axis_tkeep,
  input  logic [NUM_PORTS-1:0]         s_axis_tlast,
  input  logic [NUM_PORTS*TUSER_W-1:0] s_axis_tuser,
  output logic [NUM_PORTS-1:0]         s_axis_tready,
  output logic                         m_axis_tvalid,
  output logic [511:0]                 m_axis_tdata,
  output logic [63:0]                  m_axis_tkeep,
  output logic                         m_axis_tlast,
  output logic [TUSER_W-1:0]           m_axis_tuser,
  output logic [1:0]                   m_axis_tid,
  input  logic                         m_axis_tready,
  output logic [NUM_PORTS*32-1:0]      pkt_count
);

  typedef enum logic {
    ST_ARB  = 1'b0,
    ST_XFER = 1'b1
  } state_e;

  state_e                   state_q, state_d;
  logic [1:0]               grant_q, grant_d;
  logic [1:0]               last_grant_q, last_grant_d;
  logic [NUM_PORTS*32-1:0]  pkt_count_q, pkt_count_d;

  logic                     out_vld_q;
  logic [511:0]             out_data_q;
  logic [63:0]              out_keep_q;
  logic                     out_last_q;
  logic [TUSER_W-1:0]       out_user_q;
  logic [1:0]               out_tid_q;

  // Per-port flags padded to the 4-port maximum so a 2-bit index is always in range.
  logic [3:0]               vld_pad;
  logic [3:0]               last_pad;
  logic [3:0]               rdy_pad;

  logic                     out_ready;
  logic                     beat_acc;
  logic                     pkt_done;
  logic [2:0]               rr_idx;
  logic [1:0]               rr_pick;
  logic                     rr_found;

  logic [511:0]             sel_data;
  logic [63:0]              sel_keep;
  logic [TUSER_W-1:0]       sel_user;

  assign vld_pad  = 4'(s_axis_tvalid);
  assign last_pad = 4'(s_axis_tlast);

  // The output register may take a new beat when empty or draining this cycle.
  assign out_ready = !out_vld_q || m_axis_tready;
  assign beat_acc  = (state_q == ST_XFER) && vld_pad[grant_q] && out_ready;
  assign pkt_done  = beat_acc && last_pad[grant_q];

  assign sel_data = s_axis_tdata[int'(grant_q)*512 +: 512];
  assign sel_keep = s_axis_tkeep[int'(grant_q)*64 +: 64];
  assign sel_user = s_axis_tuser[int'(grant_q)*TUSER_W +: TUSER_W];

  // Round-robin scan starting just after the last granted port. last_grant + k is
  // below 2*NUM_PORTS, so a single conditional subtraction is a full modulo.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = 2'd0;
    rr_idx   = 3'd0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_idx = 3'(last_grant_q) + 3'(k);
      if (rr_idx >= 3'(NUM_PORTS)) begin
        rr_idx = rr_idx - 3'(NUM_PORTS);
      end
      if (!rr_found && vld_pad[rr_idx[1:0]]) begin
        rr_found = 1'b1;
        rr_pick  = rr_idx[1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    rdy_pad      = 4'd0;
    case (state_q)
      ST_ARB: begin
        if (rr_found) begin
          grant_d = rr_pick;
          state_d = ST_XFER;
        end
      end
      ST_XFER: begin
        rdy_pad[grant_q] = out_ready;
        // Grant is kept through source bubbles; only tlast releases it.
        if (pkt_done) begin
          last_grant_d = grant_q;
          state_d      = ST_ARB;
        end
      end
      default: state_d = ST_ARB;
    endcase
  end

  assign s_axis_tready = rdy_pad[NUM_PORTS-1:0];

  always_comb begin
    pkt_count_d = pkt_count_q;
    if (pkt_done) begin
      pkt_count_d[int'(grant_q)*32 +: 32] = pkt_count_q[int'(grant_q)*32 +: 32] + 32'd1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= ST_ARB;
      grant_q      <= 2'd0;
      last_grant_q <= 2'(NUM_PORTS - 1);
      pkt_count_q  <= '0;
      out_vld_q    <= 1'b0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_last_q   <= 1'b0;
      out_user_q   <= '0;
      out_tid_q    <= 2'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      pkt_count_q  <= pkt_count_d;
      if (beat_acc) begin
        out_vld_q  <= 1'b1;
        out_data_q <= sel_data;
        out_keep_q <= sel_keep;
        out_last_q <= last_pad[grant_q];
        out_user_q <= sel_user;
        out_tid_q  <= grant_q;
      end else if (out_ready) begin
        out_vld_q  <= 1'b0;
      end
    end
  end

  assign m_axis_tvalid = out_vld_q;
  assign m_axis_tdata  = out_data_q;
  assign m_axis_tkeep  = out_keep_q;
  assign m_axis_tlast  = out_last_q;
  assign m_axis_tuser  = out_user_q;
  assign m_axis_tid    = out_tid_q;
  assign pkt_count     = pkt_count_q;

endmodule

// File: tb/tb_rx_pkt_arbiter.sv
// tb/tb_rx_pkt_arbiter.sv - self-checking bench for rx_pkt_arbiter
module tb_rx_pkt_arbiter;
  localparam int NP  = 3;
  localparam int TU  = 48;
  localparam int MEM = 512;

  logic aclk = 1'b0;
  always #5 aclk = ~aclk;

  logic                 aresetn;
  logic [NP-1:0]        s_axis_tvalid;
  logic [NP*512-1:0]    s_axis_tdata;
  logic [NP*64-1:0]     s_axis_tkeep;
  logic [NP-1:0]        s_axis_tlast;
  logic [NP*TU-1:0]     s_axis_tuser;
  logic [NP-1:0]        s_axis_tready;
  logic                 m_axis_tvalid;
  logic [511:0]         m_axis_tdata;
  logic [63:0]          m_axis_tkeep;
  logic                 m_axis_tlast;
  logic [TU-1:0]        m_axis_tuser;
  logic [1:0]           m_axis_tid;
  logic                 m_axis_tready;
  logic [NP*32-1:0]     pkt_count;

  rx_pkt_arbiter #(.NUM_PORTS(NP), .TUSER_W(TU)) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tuser  (s_axis_tuser),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tid    (m_axis_tid),
    .m_axis_tready (m_axis_tready),
    .pkt_count     (pkt_count)
  );

  typedef struct {
    logic [511:0]  data;
    logic [63:0]   keep;
    logic          last;
    logic [TU-1:0] user;
    int            gap;
    logic [1:0]    tid;
  } beat_t;

  // Source side: per-port beat lists, a read pointer and an idle-gap counter.
  beat_t         src_mem [NP][MEM];
  int            wr [NP];
  int            rd [NP];
  int            wcnt [NP];
  logic [NP-1:0] acc;

  // Reference model: who owns the output, round-robin pointer, counters, and the
  // beats expected on m_axis in order.
  logic          m_busy;
  int            m_owner;
  int            m_last;
  logic [31:0]   m_cnt [NP];
  beat_t         sbq [$];
  logic          out_started;
  int            tid_log [$];

  int            n_checks;
  int            n_fail;
  int            rdy_mode;
  int            rdy_pct;
  int            rdy_idx;
  logic [3:0]    rdy_pat;
  logic [NP*32-1:0] frc_val;

  task automatic chk_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic add_beat(input int p, input logic last, input int gap);
    beat_t       b;
    logic [63:0] r64;
    for (int w = 0; w < 16; w++) b.data[w*32 +: 32] = $urandom;
    b.keep[31:0]  = $urandom;
    b.keep[63:32] = $urandom;
    r64[31:0]     = $urandom;
    r64[63:32]    = $urandom;
    b.user        = r64[TU-1:0];
    b.last        = last;
    b.gap         = gap;
    b.tid         = 2'(p);
    src_mem[p][wr[p]] = b;
    wr[p]++;
  endtask

  task automatic add_pkt(input int p, input int len, input int maxgap);
    for (int i = 0; i < len; i++) add_beat(p, (i == len - 1), $urandom_range(0, maxgap));
  endtask

  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      if (s_axis_tvalid[p] && acc[p]) begin
        rd[p]++;
        s_axis_tvalid[p] = 1'b0;
      end
      if (!s_axis_tvalid[p] && rd[p] < wr[p]) begin
        if (wcnt[p] >= src_mem[p][rd[p]].gap) begin
          s_axis_tvalid[p] = 1'b1;
          wcnt[p] = 0;
        end else begin
          wcnt[p]++;
        end
      end
      if (rd[p] < wr[p]) begin
        s_axis_tdata[p*512 +: 512] = src_mem[p][rd[p]].data;
        s_axis_tkeep[p*64 +: 64]   = src_mem[p][rd[p]].keep;
        s_axis_tlast[p]            = src_mem[p][rd[p]].last;
        s_axis_tuser[p*TU +: TU]   = src_mem[p][rd[p]].user;
      end else begin
        s_axis_tdata[p*512 +: 512] = '0;
        s_axis_tkeep[p*64 +: 64]   = '0;
        s_axis_tlast[p]            = 1'b0;
        s_axis_tuser[p*TU +: TU]   = '0;
      end
    end
    acc = '0;
    if (rdy_mode == 1) begin
      m_axis_tready = rdy_pat[rdy_idx % 4];
      rdy_idx++;
    end else begin
      m_axis_tready = ($urandom_range(0, 99) < rdy_pct);
    end
  endtask

  // Evaluated mid-cycle: compare DUT outputs with the model, then advance the model
  // by the handshakes that the coming clock edge will perform.
  task automatic model_step();
    logic          exp_mv;
    logic          out_rdy;
    logic [NP-1:0] exp_sr;
    logic          old_busy;
    exp_mv  = (sbq.size() != 0);
    out_rdy = !exp_mv || m_axis_tready;
    exp_sr  = '0;
    if (m_busy) exp_sr[m_owner] = out_rdy;
    chk_eq("s_tready", 512'(s_axis_tready), 512'(exp_sr));
    chk_eq("m_tvalid", 512'(m_axis_tvalid), 512'(exp_mv));
    if (exp_mv) begin
      chk_eq("m_tdata", m_axis_tdata, sbq[0].data);
      chk_eq("m_tkeep", 512'(m_axis_tkeep), 512'(sbq[0].keep));
      chk_eq("m_tlast", 512'(m_axis_tlast), 512'(sbq[0].last));
      chk_eq("m_tuser", 512'(m_axis_tuser), 512'(sbq[0].user));
      chk_eq("m_tid", 512'(m_axis_tid), 512'(sbq[0].tid));
    end
    for (int p = 0; p < NP; p++) chk_eq("pkt_count", 512'(pkt_count[p*32 +: 32]), 512'(m_cnt[p]));
    acc = s_axis_tvalid & s_axis_tready;
    if (exp_mv && m_axis_tready) begin
      if (!out_started) tid_log.push_back(int'(sbq[0].tid));
      out_started = !sbq[0].last;
      void'(sbq.pop_front());
    end
    old_busy = m_busy;
    if (old_busy) begin
      if (s_axis_tvalid[m_owner] && out_rdy) begin
        sbq.push_back(src_mem[m_owner][rd[m_owner]]);
        if (src_mem[m_owner][rd[m_owner]].last) begin
          m_cnt[m_owner]++;
          m_last = m_owner;
          m_busy = 1'b0;
        end
      end
    end else begin
      for (int k = 1; k <= NP; k++) begin
        int q;
        q = (m_last + k) % NP;
        if (!m_busy && s_axis_tvalid[q]) begin
          m_busy  = 1'b1;
          m_owner = q;
        end
      end
    end
  endtask

  task automatic cycle();
    @(negedge aclk);
    model_step();
    @(posedge aclk);
    #1;
    drive();
  endtask

  task automatic model_reset();
    m_busy      = 1'b0;
    m_owner     = 0;
    m_last      = NP - 1;
    out_started = 1'b0;
    sbq.delete();
    for (int p = 0; p < NP; p++) begin
      m_cnt[p] = 32'd0;
      rd[p]    = wr[p];
      wcnt[p]  = 0;
    end
    acc           = '0;
    s_axis_tvalid = '0;
  endtask

  task automatic drain(input int limit);
    logic done;
    done = 1'b0;
    for (int n = 0; n < limit && !done; n++) begin
      cycle();
      done = !m_busy && (sbq.size() == 0) && (s_axis_tvalid == '0);
      for (int p = 0; p < NP; p++) if (rd[p] < wr[p]) done = 1'b0;
    end
    chk_eq("drain_done", 512'(done), 512'(1'b1));
  endtask

  initial begin
    logic [31:0] base [NP];
    int          sum;
    n_checks = 0;
    n_fail   = 0;
    rdy_mode = 0;
    rdy_pct  = 100;
    rdy_idx  = 0;
    rdy_pat  = 4'b1001;
    for (int p = 0; p < NP; p++) begin
      wr[p] = 0;
      rd[p] = 0;
    end
    aresetn       = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tlast  = '0;
    s_axis_tuser  = '0;
    m_axis_tready = 1'b1;
    model_reset();

    // Reset state
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    chk_eq("rst_m_tvalid", 512'(m_axis_tvalid), 512'(0));
    chk_eq("rst_m_tdata", m_axis_tdata, 512'(0));
    chk_eq("rst_m_tkeep", 512'(m_axis_tkeep), 512'(0));
    chk_eq("rst_m_tlast", 512'(m_axis_tlast), 512'(0));
    chk_eq("rst_m_tuser", 512'(m_axis_tuser), 512'(0));
    chk_eq("rst_m_tid", 512'(m_axis_tid), 512'(0));
    chk_eq("rst_s_tready", 512'(s_axis_tready), 512'(0));
    chk_eq("rst_pkt_count", 512'(pkt_count), 512'(0));
    @(posedge aclk);
    #1;
    aresetn = 1'b1;

    // Single 3-beat packet on port 0
    add_pkt(0, 3, 0);
    drive();
    drain(50);
    chk_eq("t1_npkts", 512'(tid_log.size()), 512'(1));
    if (tid_log.size() > 0) chk_eq("t1_tid", 512'(tid_log[0]), 512'(0));
    chk_eq("t1_cnt0", 512'(pkt_count[31:0]), 512'(1));
    chk_eq("t1_cnt1", 512'(pkt_count[63:32]), 512'(0));

    // Ports 0 and 1 both streaming 2-beat packets; last grant was 0, so 1 leads
    tid_log.delete();
    for (int p = 0; p < NP; p++) base[p] = pkt_count[p*32 +: 32];
    for (int i = 0; i < 4; i++) begin
      add_pkt(0, 2, 0);
      add_pkt(1, 2, 0);
    end
    drain(200);
    chk_eq("t2_npkts", 512'(tid_log.size()), 512'(8));
    for (int i = 0; i < tid_log.size(); i++) chk_eq("t2_order", 512'(tid_log[i]), 512'((i % 2 == 0) ? 1 : 0));
    chk_eq("t2_cnt0", 512'(pkt_count[31:0] - base[0]), 512'(4));
    chk_eq("t2_cnt1", 512'(pkt_count[63:32] - base[1]), 512'(4));

    // Port 1 bubbles mid-packet while port 0 waits
    tid_log.delete();
    add_beat(1, 1'b0, 0);
    add_beat(1, 1'b0, 0);
    add_beat(1, 1'b0, 3);
    add_beat(1, 1'b1, 0);
    add_beat(0, 1'b0, 2);
    add_beat(0, 1'b1, 0);
    drain(100);
    chk_eq("t3_npkts", 512'(tid_log.size()), 512'(2));
    if (tid_log.size() == 2) begin
      chk_eq("t3_first", 512'(tid_log[0]), 512'(1));
      chk_eq("t3_second", 512'(tid_log[1]), 512'(0));
    end

    // Downstream ready pattern 1,0,0,1 over a 4-beat packet from port 2
    rdy_mode = 1;
    rdy_idx  = 0;
    add_pkt(2, 4, 0);
    drain(100);
    rdy_mode = 0;

    // Counter wrap on port 0
    frc_val = pkt_count;
    frc_val[31:0] = 32'hFFFF_FFFE;
    force dut.pkt_count_q = frc_val;
    m_cnt[0] = 32'hFFFF_FFFE;
    cycle();
    cycle();
    release dut.pkt_count_q;
    add_beat(0, 1'b1, 0);
    drain(50);
    chk_eq("t5_wrap_ff", 512'(pkt_count[31:0]), 512'(32'hFFFF_FFFF));
    add_beat(0, 1'b1, 1);
    drain(50);
    chk_eq("t5_wrap_00", 512'(pkt_count[31:0]), 512'(32'h0000_0000));

    // Randomized traffic on all ports with bubbles and backpressure
    rdy_pct = 70;
    for (int p = 0; p < NP; p++) base[p] = pkt_count[p*32 +: 32];
    for (int i = 0; i < 60; i++) add_pkt($urandom_range(0, NP - 1), $urandom_range(1, 5), 3);
    drain(4000);
    sum = 0;
    for (int p = 0; p < NP; p++) sum += int'(pkt_count[p*32 +: 32] - base[p]);
    chk_eq("rand_pkts", 512'(sum), 512'(60));

    // Asynchronous reset in the middle of a packet
    rdy_pct = 100;
    tid_log.delete();
    add_pkt(0, 6, 0);
    repeat (4) cycle();
    chk_eq("t6_pre_mvalid", 512'(m_axis_tvalid), 512'(1));
    #2;
    aresetn = 1'b0;
    #1;
    chk_eq("t6_rst_mvalid", 512'(m_axis_tvalid), 512'(0));
    chk_eq("t6_rst_mdata", m_axis_tdata, 512'(0));
    chk_eq("t6_rst_sready", 512'(s_axis_tready), 512'(0));
    chk_eq("t6_rst_count", 512'(pkt_count), 512'(0));
    model_reset();
    tid_log.delete();
    repeat (2) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    add_pkt(1, 2, 0);
    add_pkt(0, 2, 0);
    drive();
    drain(100);
    chk_eq("t6_npkts", 512'(tid_log.size()), 512'(2));
    if (tid_log.size() == 2) begin
      chk_eq("t6_first", 512'(tid_log[0]), 512'(0));
      chk_eq("t6_second", 512'(tid_log[1]), 512'(1));
    end
    chk_eq("t6_cnt1", 512'(pkt_count[63:32]), 512'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
